// File: rtl/alu_flag_mul_unit.sv
// ALU, {Z,C,N,O} flag register and iterative shift-add multiplier that sit
// directly after the register file read ports.
module alu_flag_mul_unit #(
    parameter int WIDTH = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [3:0]           FunSel,
    input  logic                 WF,
    input  logic                 Start,
    output logic [WIDTH-1:0]     ALUOut,
    output logic [3:0]           FlagsOut,
    output logic [2*WIDTH-1:0]   MulOut,
    output logic                 Busy,
    output logic                 Done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic             cin;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   adc_sum;
    logic [WIDTH:0]   sub_sum;
    logic [WIDTH-1:0] alu_res;
    logic             z_next;
    logic             c_next;
    logic             n_next;
    logic             o_next;

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [CW-1:0]      count;
    logic               last_step;

    assign cin     = FlagsOut[2];
    assign add_sum = {1'b0, A} + {1'b0, B};
    assign adc_sum = add_sum + {{WIDTH{1'b0}}, cin};
    // Subtraction as A + ~B + 1 so bit WIDTH is the no-borrow carry.
    assign sub_sum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

    // ALU result plus the C and O candidates; ops that do not define C/O hold them.
    always_comb begin
        alu_res = A;
        c_next  = FlagsOut[2];
        o_next  = FlagsOut[0];
        case (FunSel)
            4'b0000: alu_res = A;
            4'b0001: alu_res = B;
            4'b0010: alu_res = ~A;
            4'b0011: alu_res = ~B;
            4'b0100: begin
                alu_res = add_sum[WIDTH-1:0];
                c_next  = add_sum[WIDTH];
                o_next  = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0101: begin
                alu_res = adc_sum[WIDTH-1:0];
                c_next  = adc_sum[WIDTH];
                o_next  = (A[WIDTH-1] == B[WIDTH-1]) && (adc_sum[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0110: begin
                alu_res = sub_sum[WIDTH-1:0];
                c_next  = sub_sum[WIDTH];
                o_next  = (A[WIDTH-1] != B[WIDTH-1]) && (sub_sum[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0111: alu_res = A & B;
            4'b1000: alu_res = A | B;
            4'b1001: alu_res = A ^ B;
            4'b1010: alu_res = ~(A & B);
            4'b1011: begin
                alu_res = {A[WIDTH-2:0], 1'b0};
                c_next  = A[WIDTH-1];
            end
            4'b1100: begin
                alu_res = {1'b0, A[WIDTH-1:1]};
                c_next  = A[0];
            end
            4'b1101: begin
                alu_res = {A[WIDTH-1], A[WIDTH-1:1]};
                c_next  = A[0];
            end
            4'b1110: begin
                alu_res = {A[WIDTH-2:0], cin};
                c_next  = A[WIDTH-1];
            end
            4'b1111: begin
                alu_res = {cin, A[WIDTH-1:1]};
                c_next  = A[0];
            end
            default: alu_res = A;
        endcase
    end

    assign z_next = (alu_res == '0);
    assign n_next = alu_res[WIDTH-1];
    assign ALUOut = alu_res;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            FlagsOut <= 4'b0000;
        end else if (WF) begin
            FlagsOut <= {z_next, c_next, n_next, o_next};
        end
    end

    // One shift-add step; the final step's sum goes straight to MulOut.
    assign acc_step  = mplier[0] ? (acc + mcand) : acc;
    assign last_step = (count == CW'(WIDTH - 1));

    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            MulOut <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        mcand  <= {{WIDTH{1'b0}}, A};
                        mplier <= B;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_step;
                    mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    count  <= count + CW'(1);
                    if (last_step) begin
                        MulOut <= acc_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_flag_mul_unit.sv
// Directed-vector bench for alu_flag_mul_unit: ALU ops, flag updates,
// multiplier handshake/latency and reset abort.
module tb_alu_flag_mul_unit;

    logic        Clock;
    logic        Reset;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  FunSel;
    logic        WF;
    logic        Start;
    logic [15:0] ALUOut;
    logic [3:0]  FlagsOut;
    logic [31:0] MulOut;
    logic        Busy;
    logic        Done;

    int checks = 0;
    int errors = 0;

    alu_flag_mul_unit #(.WIDTH(16)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .A        (A),
        .B        (B),
        .FunSel   (FunSel),
        .WF       (WF),
        .Start    (Start),
        .ALUOut   (ALUOut),
        .FlagsOut (FlagsOut),
        .MulOut   (MulOut),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic wf);
        FunSel = op;
        A      = a;
        B      = b;
        WF     = wf;
        #1;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic aluVector(input string tag, input logic [3:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] expected);
        applyStimulus(op, a, b, 1'b0);
        checkOutput(tag, 32'(ALUOut), 32'(expected));
    endtask

    int busyCnt;
    int doneCnt;
    int doneAt;
    int doneSeen;
    bit finished;

    initial begin
        Reset  = 1'b0;
        Start  = 1'b0;
        A      = '0;
        B      = '0;
        FunSel = '0;
        WF     = 1'b0;
        repeat (2) tick();
        checkOutput("rst_flags", 32'(FlagsOut), 32'h0);
        checkOutput("rst_mulout", MulOut, 32'h0);
        checkOutput("rst_busy", 32'(Busy), 32'h0);
        checkOutput("rst_done", 32'(Done), 32'h0);
        Reset = 1'b1;
        tick();

        // Signed overflow on add
        applyStimulus(4'b0100, 16'h7FFF, 16'h0001, 1'b1);
        checkOutput("add_ovf_res", 32'(ALUOut), 32'h8000);
        tick();
        checkOutput("add_ovf_flags", 32'(FlagsOut), 32'h3);

        // Carry out to set C, then add-with-carry
        applyStimulus(4'b0100, 16'hFFFF, 16'h0001, 1'b1);
        checkOutput("add_carry_res", 32'(ALUOut), 32'h0000);
        tick();
        checkOutput("add_carry_flags", 32'(FlagsOut), 32'hC);
        applyStimulus(4'b0101, 16'h0001, 16'h0001, 1'b0);
        checkOutput("adc_res", 32'(ALUOut), 32'h0003);
        tick();
        checkOutput("adc_nowf_flags", 32'(FlagsOut), 32'hC);

        applyStimulus(4'b0110, 16'h1234, 16'h1234, 1'b1);
        checkOutput("sub_eq_res", 32'(ALUOut), 32'h0000);
        tick();
        checkOutput("sub_eq_flags", 32'(FlagsOut), 32'hC);

        applyStimulus(4'b1111, 16'h0002, 16'h0000, 1'b1);
        checkOutput("csr_res", 32'(ALUOut), 32'h8001);
        tick();
        checkOutput("csr_flags", 32'(FlagsOut), 32'h2);

        applyStimulus(4'b1101, 16'h8004, 16'h0000, 1'b1);
        checkOutput("asr_res", 32'(ALUOut), 32'hC002);
        tick();
        checkOutput("asr_flags", 32'(FlagsOut), 32'h2);

        // Remaining ops with C=0
        aluVector("pass_a", 4'b0000, 16'h1234, 16'hABCD, 16'h1234);
        aluVector("pass_b", 4'b0001, 16'h1234, 16'hABCD, 16'hABCD);
        aluVector("not_a",  4'b0010, 16'h1234, 16'hABCD, 16'hEDCB);
        aluVector("not_b",  4'b0011, 16'h1234, 16'hABCD, 16'h5432);
        aluVector("and",    4'b0111, 16'h1234, 16'hABCD, 16'h0204);
        aluVector("or",     4'b1000, 16'h1234, 16'hABCD, 16'hBBFD);
        aluVector("xor",    4'b1001, 16'h1234, 16'hABCD, 16'hB9F9);
        aluVector("nand",   4'b1010, 16'h1234, 16'hABCD, 16'hFDFB);
        aluVector("lsl",    4'b1011, 16'h1234, 16'h0000, 16'h2468);
        aluVector("lsr",    4'b1100, 16'h1234, 16'h0000, 16'h091A);
        aluVector("csl_c0", 4'b1110, 16'h8001, 16'h0000, 16'h0002);
        aluVector("sub_neg", 4'b0110, 16'h0005, 16'h0007, 16'hFFFE);
        aluVector("adc_c0", 4'b0101, 16'h0001, 16'h0001, 16'h0002);
        tick();
        checkOutput("vec_nowf_flags", 32'(FlagsOut), 32'h2);

        // Signed overflow on subtract
        applyStimulus(4'b0110, 16'h8000, 16'h0001, 1'b1);
        checkOutput("sub_ovf_res", 32'(ALUOut), 32'h7FFF);
        tick();
        checkOutput("sub_ovf_flags", 32'(FlagsOut), 32'h5);

        applyStimulus(4'b1110, 16'h0001, 16'h0000, 1'b1);
        checkOutput("csl_c1_res", 32'(ALUOut), 32'h0003);
        tick();
        checkOutput("csl_c1_flags", 32'(FlagsOut), 32'h1);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0000, 16'(i * 3 + 1), 16'h0000, 1'b0);
            checkOutput("hold_alu", 32'(ALUOut), 32'(i * 3 + 1));
            tick();
            checkOutput("hold_flags", 32'(FlagsOut), 32'h1);
        end

        // Full-scale multiply with an ignored Start and operand change mid-run
        applyStimulus(4'b0000, 16'hFFFF, 16'hFFFF, 1'b0);
        Start = 1'b1;
        tick();
        Start   = 1'b0;
        busyCnt = 0;
        doneCnt = 0;
        doneAt  = -1;
        for (int k = 0; k < 24; k++) begin
            if (Busy) busyCnt++;
            if (Done) begin
                doneCnt++;
                doneAt = k;
            end
            if (k == 3) begin
                Start = 1'b1;
                A     = 16'h0002;
                B     = 16'h0003;
            end else if (k == 4) begin
                Start = 1'b0;
            end
            tick();
        end
        checkOutput("mul_busy_cycles", busyCnt, 16);
        checkOutput("mul_done_count", doneCnt, 1);
        checkOutput("mul_done_cycle", doneAt, 16);
        checkOutput("mul_product", MulOut, 32'hFFFE0001);
        checkOutput("mul_idle_busy", 32'(Busy), 32'h0);
        checkOutput("mul_flags_untouched", 32'(FlagsOut), 32'h1);

        // Abort mid-multiply with reset
        applyStimulus(4'b0000, 16'h1234, 16'h0010, 1'b0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (7) tick();
        checkOutput("abort_busy_before", 32'(Busy), 32'h1);
        Reset = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(Busy), 32'h0);
        checkOutput("abort_done", 32'(Done), 32'h0);
        checkOutput("abort_mulout", MulOut, 32'h0);
        checkOutput("abort_flags", 32'(FlagsOut), 32'h0);
        doneSeen = 0;
        repeat (2) tick();
        Reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (Done || Busy) doneSeen++;
            tick();
        end
        checkOutput("abort_no_done", doneSeen, 0);
        checkOutput("abort_mulout_held", MulOut, 32'h0);

        applyStimulus(4'b0000, 16'h0003, 16'h0005, 1'b0);
        Start = 1'b1;
        tick();
        Start    = 1'b0;
        finished = 1'b0;
        for (int k = 0; k < 40 && !finished; k++) begin
            if (Done) finished = 1'b1;
            else tick();
        end
        checkOutput("mul2_done_seen", 32'(finished), 32'h1);
        checkOutput("mul2_product", MulOut, 32'h0000000F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
